// File: rtl/pulse_cnt_mc.sv
// ---------------------------------------------------------------------------
// pulse_cnt_mc -- multi-channel pulse/event counter with rate windows
//
// Purpose:
//   CH independent saturating event counters. Each channel counts either the
//   cycles its input is high (level mode) or its rising edges (edge mode).
//   A periodic measurement window snapshots every counter (including the
//   event arriving in the tick cycle) and restarts it, giving per-window
//   rates. Saturation sets a sticky per-channel overflow flag. Results are
//   read through a registered, channel-muxed read port.
//
// Configuration macro:
//   PULSE_CNT_SYNC_EN  defined   : d_i passes through a 2-flop synchronizer
//                                  per channel (d_i may be asynchronous,
//                                  +2 cycles event-to-count latency).
//                      undefined : d_i is used directly and must be
//                                  synchronous to clk.
//
// Ports:
//   clk        in   1          system clock
//   rst_n      in   1          asynchronous active-low reset
//   clc        in   1          synchronous clear of counters, snapshots,
//                              overflow flags and the window counter
//   d_i        in   CH         per-channel event inputs
//   edge_mode  in   CH         1: count rising edges, 0: count high cycles
//   win_en     in   1          enable periodic window snapshots
//   win_len    in   WIN_W      window length in cycles (0: no ticks)
//   rd_sel     in   SEL_W      channel select for the read port
//   rd_cnt     out  CNT_WIDTH  live count of channel rd_sel (registered)
//   rd_snap    out  CNT_WIDTH  last snapshot of channel rd_sel (registered)
//   snap_vld   out  1          one-cycle pulse: snapshot set updated
//   ovf        out  CH         sticky per-channel saturation flags
// ---------------------------------------------------------------------------
module pulse_cnt_mc #(
  parameter  int CH        = 4,
  parameter  int CNT_WIDTH = 32,
  parameter  int WIN_W     = 24,
  localparam int SEL_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clc,
  input  logic [CH-1:0]        d_i,
  input  logic [CH-1:0]        edge_mode,
  input  logic                 win_en,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_WIDTH-1:0] rd_cnt,
  output logic [CNT_WIDTH-1:0] rd_snap,
  output logic                 snap_vld,
  output logic [CH-1:0]        ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [CH-1:0] d_s;   // conditioned event level used by the counters
  logic [CH-1:0] d_q;   // previous-cycle d_s, for rising-edge detection

`ifdef PULSE_CNT_SYNC_EN
  logic [CH-1:0] sync1_q;
  logic [CH-1:0] sync2_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; with blocking (=) sync2_q would see this cycle's
  // sync1_q and the two stages would collapse into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign d_s = sync2_q;
`else
  assign d_s = d_i;
`endif

  // d_q follows d_s every cycle, independent of clc. Because it resets to 0,
  // an input already high when reset releases counts as one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
    end else begin
      d_q <= d_s;
    end
  end

  logic [CH-1:0] inc;
  assign inc = (edge_mode & d_s & ~d_q) | (~edge_mode & d_s);

  // -------------------------------------------------------------------------
  // Measurement window
  // -------------------------------------------------------------------------
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_active;
  logic             tick;

  assign win_active = win_en && (win_len != '0);
  // '>=' rather than '==' so that shrinking win_len below the current count
  // ends the window at once instead of waiting for a counter wrap.
  assign tick       = win_active && (win_cnt_q >= (win_len - WIN_W'(1)));

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (clc || !win_active || tick) begin
      win_cnt_d = '0;
    end else begin
      win_cnt_d = win_cnt_q + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel counters, snapshots and overflow flags
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q  [CH];
  logic [CNT_WIDTH-1:0] cnt_d  [CH];
  logic [CNT_WIDTH-1:0] snap_q [CH];
  logic [CNT_WIDTH-1:0] snap_d [CH];
  logic [CNT_WIDTH-1:0] sum    [CH];   // saturating cnt + inc
  logic [CH-1:0]        sat_hit;       // inc arrived while counter at max
  logic [CH-1:0]        ovf_q, ovf_d;
  logic                 snap_vld_q, snap_vld_d;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sat_hit[i] = inc[i] && (cnt_q[i] == CNT_MAX);
      sum[i]     = (inc[i] && !sat_hit[i]) ? cnt_q[i] + CNT_WIDTH'(1) : cnt_q[i];
    end
  end

  // Priority: clc > tick > inc. A tick folds the same-cycle event into the
  // snapshot and restarts the live counter from zero.
  always_comb begin
    ovf_d      = ovf_q;
    snap_vld_d = 1'b0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      snap_d[i] = snap_q[i];
    end

    if (clc) begin
      ovf_d = '0;
      for (int i = 0; i < CH; i++) begin
        cnt_d[i]  = '0;
        snap_d[i] = '0;
      end
    end else begin
      snap_vld_d = tick;
      ovf_d      = ovf_q | sat_hit;
      for (int i = 0; i < CH; i++) begin
        if (tick) begin
          snap_d[i] = sum[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i]  = sum[i];
        end
      end
    end
  end

  // NOTE: the counter and snapshot arrays are ordinary flops that must read 0
  // after reset, so they are reset element by element; a large RAM-style
  // array would be left unreset so it could map onto memory macros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q      <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
      ovf_q      <= ovf_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read port
  // -------------------------------------------------------------------------
  // A compare-per-channel mux never indexes past CH-1, so selects >= CH
  // naturally fall through to the zero default.
  logic [CNT_WIDTH-1:0] rd_cnt_q,  rd_cnt_d;
  logic [CNT_WIDTH-1:0] rd_snap_q, rd_snap_d;

  always_comb begin
    rd_cnt_d  = '0;
    rd_snap_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_cnt_d  = cnt_q[i];
        rd_snap_d = snap_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      rd_snap_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      rd_snap_q <= rd_snap_d;
    end
  end

  assign rd_cnt   = rd_cnt_q;
  assign rd_snap  = rd_snap_q;
  assign snap_vld = snap_vld_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_cnt_mc.sv
// ---------------------------------------------------------------------------
// tb_pulse_cnt_mc -- self-checking bench for pulse_cnt_mc (CH=4, CNT_WIDTH=8)
//
// A cycle-level reference model in plain integer arithmetic predicts every
// registered output; directed scenarios add fixed expected values, followed
// by randomized traffic.
// ---------------------------------------------------------------------------
module tb_pulse_cnt_mc;

  localparam int CH    = 4;
  localparam int CW    = 8;
  localparam int WW    = 24;
  localparam int MAXV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clc;
  logic [CH-1:0] d_i;
  logic [CH-1:0] edge_mode;
  logic          win_en;
  logic [WW-1:0] win_len;
  logic [1:0]    rd_sel;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] rd_snap;
  logic          snap_vld;
  logic [CH-1:0] ovf;

  pulse_cnt_mc #(.CH(CH), .CNT_WIDTH(CW), .WIN_W(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clc       (clc),
    .d_i       (d_i),
    .edge_mode (edge_mode),
    .win_en    (win_en),
    .win_len   (win_len),
    .rd_sel    (rd_sel),
    .rd_cnt    (rd_cnt),
    .rd_snap   (rd_snap),
    .snap_vld  (snap_vld),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt  [CH];
  int m_snap [CH];
  bit m_ovf  [CH];
  bit m_prev [CH];
  bit m_s1   [CH];
  bit m_s2   [CH];
  int m_win;
  int m_rd_cnt, m_rd_snap;
  bit m_vld;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 0;
      m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
    end
    m_win = 0; m_rd_cnt = 0; m_rd_snap = 0; m_vld = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_eval();
    bit ds [CH];
    bit ev;
    bit active, tk;
    int v;
    for (int i = 0; i < CH; i++) begin
`ifdef PULSE_CNT_SYNC_EN
      ds[i] = m_s2[i];
`else
      ds[i] = d_i[i];
`endif
    end
    m_rd_cnt  = (int'(rd_sel) < CH) ? m_cnt[rd_sel]  : 0;
    m_rd_snap = (int'(rd_sel) < CH) ? m_snap[rd_sel] : 0;
    active = win_en && (win_len != 0);
    tk     = active && (m_win + 1 >= int'(win_len));
    if (clc) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 0;
      end
      m_win = 0;
      m_vld = 0;
    end else begin
      m_vld = tk;
      for (int i = 0; i < CH; i++) begin
        ev = edge_mode[i] ? (ds[i] && !m_prev[i]) : ds[i];
        v  = m_cnt[i] + int'(ev);
        if (v > MAXV) begin
          v = MAXV;
          m_ovf[i] = 1;
        end
        if (tk) begin
          m_snap[i] = v;
          m_cnt[i]  = 0;
        end else begin
          m_cnt[i]  = v;
        end
      end
      m_win = (!active || tk) ? 0 : m_win + 1;
    end
    for (int i = 0; i < CH; i++) begin
      m_prev[i] = ds[i];
      m_s2[i]   = m_s1[i];
      m_s1[i]   = d_i[i];
    end
  endtask

  function automatic logic [CH-1:0] model_ovf();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_ovf[i];
    return r;
  endfunction

  // One clock: predict, clock, then compare all outputs 1 time unit later.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("rd_cnt",   32'(rd_cnt),   32'(m_rd_cnt));
    check("rd_snap",  32'(rd_snap),  32'(m_rd_snap));
    check("snap_vld", 32'(snap_vld), 32'(m_vld));
    check("ovf",      32'(ovf),      32'(model_ovf()));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_step();
    clc = 1'b1;
    step();
    clc = 1'b0;
  endtask

  int nvld;
  bit found;

  initial begin
    rst_n = 1'b0; clc = 1'b0; d_i = '0; edge_mode = '0;
    win_en = 1'b0; win_len = '0; rd_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_cnt",   32'(rd_cnt),   0);
    check("reset_rd_snap",  32'(rd_snap),  0);
    check("reset_snap_vld", 32'(snap_vld), 0);
    check("reset_ovf",      32'(ovf),      0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: level mode, 10 high cycles on channel 0
    rd_sel = 2'd0;
    d_i = 4'b0001;
    steps(10);
    d_i = '0;
    steps(4);
    check("t1_level_cnt", 32'(rd_cnt), 10);

    // 2: edge mode vs level mode, 5 pulses of 3 cycles on channel 1
    rd_sel = 2'd1;
    clear_step();
    edge_mode = 4'b0010;
    for (int p = 0; p < 5; p++) begin
      d_i = 4'b0010; steps(3);
      d_i = '0;      steps(2);
    end
    steps(2);
    check("t2_edge_cnt", 32'(rd_cnt), 5);
    clear_step();
    edge_mode = '0;
    for (int p = 0; p < 5; p++) begin
      d_i = 4'b0010; steps(3);
      d_i = '0;      steps(2);
    end
    steps(2);
    check("t2_level_cnt", 32'(rd_cnt), 15);

    // 3: saturation and sticky overflow on channel 2, then clc
    rd_sel = 2'd2;
    clear_step();
    d_i = 4'b0100;
    steps(300);
    d_i = '0;
    steps(4);
    check("t3_sat_cnt", 32'(rd_cnt), MAXV);
    check("t3_ovf",     32'(ovf[2]), 1);
    clear_step();
    check("t3_ovf_clr", 32'(ovf), 0);
    step();
    check("t3_cnt_clr", 32'(rd_cnt), 0);

    // 4: windowed rate on channel 3, input high continuously
    rd_sel = 2'd3;
    win_en = 1'b1;
    win_len = 24'd100;
    d_i = 4'b1000;
    clear_step();
    nvld = 0;
    for (int k = 0; k < 350; k++) begin
      step();
      if (snap_vld) nvld++;
    end
    check("t4_vld_count", 32'(nvld), 3);
    check("t4_snap", 32'(rd_snap), 100);

    // 5: clc in the tick cycle suppresses the snapshot
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_win == 99) found = 1;
      else step();
    end
    check("t5_align", 32'(found), 1);
    clear_step();
    check("t5_no_vld", 32'(snap_vld), 0);
    step();
    check("t5_snap_zero", 32'(rd_snap), 0);
    check("t5_cnt_zero",  32'(rd_cnt),  0);

    // 6: async reset mid-window with nonzero counts
    steps(150);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rd_cnt",   32'(rd_cnt),   0);
    check("t6_rd_snap",  32'(rd_snap),  0);
    check("t6_snap_vld", 32'(snap_vld), 0);
    check("t6_ovf",      32'(ovf),      0);
    model_reset();
    d_i = '0; win_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random phase A: short windows, occasional clc, mode changes
    win_en = 1'b1;
    win_len = 24'd7;
    for (int k = 0; k < 1500; k++) begin
      d_i    = CH'($urandom);
      rd_sel = 2'($urandom);
      clc    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) edge_mode = CH'($urandom);
      if ($urandom_range(0, 63) == 0) win_len = WW'($urandom_range(0, 20));
      if ($urandom_range(0, 99) == 0) win_en = ~win_en;
      step();
    end
    clc = 1'b0;

    // Random phase B: no window, dense input to reach saturation
    win_en = 1'b0;
    edge_mode = 4'b0011;
    for (int k = 0; k < 700; k++) begin
      d_i    = CH'($urandom | $urandom);
      rd_sel = 2'($urandom);
      step();
    end
    win_en = 1'b1;
    win_len = 24'd5;
    steps(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
